sha256_core_v2: RTL and testbench

//  Parametrised, multi-block SHA-256 compression engine. Successor to the single-block compute core.

---
 rtl/sha256_core_v2.sv | 190 +++++++++++++++++++
 tb/tb_sha256_core_v2.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_v2.sv
// Multi-block SHA-256 compression engine: valid/ready block input, first/last chaining, RPC rounds per clock.
// Optional feature macro SHA224_MODE_EN adds the mode224 input (SHA-224 IVs, digest[31:0] forced to 0).
module sha256_core_v2 #(
  parameter int unsigned RPC  = 1,
  parameter int unsigned NRND = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_MODE_EN
  input  logic         mode224,
`endif
  input  logic [511:0] block,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam int unsigned WW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned CW = 7;

  typedef logic [WW-1:0] word_t;
  typedef logic [7:0][WW-1:0] vec8_t;      // element 0 = a / H0
  typedef logic [NW-1:0][WW-1:0] win_t;    // element 0 = oldest word W_t
  typedef enum logic [1:0] {IDLE, ROUNDS, UPDATE} state_t;

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
      $error("sha256_core_v2: RPC must be 1, 2 or 4");
    end
    if (NRND != 64) begin : g_bad_nrnd
      $error("sha256_core_v2: NRND must be 64");
    end
  endgenerate

  localparam vec8_t IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                             32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
`ifdef SHA224_MODE_EN
  localparam vec8_t IV224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                             32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
`endif

  localparam logic [WW-1:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WW - n));
  endfunction

  function automatic word_t big_s0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_s1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t sm_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sm_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round; shifting the packed vector moves a..g into b..h.
  function automatic vec8_t round_step(input vec8_t s, input word_t k, input word_t w);
    word_t t1;
    word_t t2;
    vec8_t r;
    t1   = s[7] + big_s1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2   = big_s0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r    = s << WW;
    r[0] = t1 + t2;
    r[4] = s[3] + t1;
    return r;
  endfunction

  state_t           state;
  vec8_t            h;
  vec8_t            av;
  win_t             win;
  logic [CW-1:0]    cnt;
  logic             last_q;
`ifdef SHA224_MODE_EN
  logic             mode_q;
`endif

  word_t            ext [NW+RPC];
  vec8_t            st  [RPC+1];
  win_t             win_nxt;
  win_t             blk_win;
  vec8_t            iv_sel;

  // Schedule extension and cascaded rounds for this cycle.
  always_comb begin
    for (int i = 0; i < int'(NW); i++) ext[i] = win[i];
    for (int j = 0; j < int'(RPC); j++)
      ext[NW+j] = sm_s1(ext[NW-2+j]) + ext[NW-7+j] + sm_s0(ext[j+1]) + ext[j];
    st[0] = av;
    for (int j = 0; j < int'(RPC); j++)
      st[j+1] = round_step(st[j], KT[6'(cnt + CW'(j))], ext[j]);
    for (int i = 0; i < int'(NW); i++) win_nxt[i] = ext[i+RPC];
  end

  always_comb begin
    for (int i = 0; i < int'(NW); i++) blk_win[i] = block[(NW-1-i)*WW +: WW];
`ifdef SHA224_MODE_EN
    iv_sel = mode224 ? IV224 : IV256;
`else
    iv_sel = IV256;
`endif
  end

  always_comb begin
    for (int i = 0; i < 8; i++) digest[(7-i)*WW +: WW] = h[i];
`ifdef SHA224_MODE_EN
    if (mode_q) digest[WW-1:0] = '0;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      h            <= IV256;
      av           <= '0;
      win          <= '0;
      cnt          <= '0;
      last_q       <= 1'b0;
      blk_ready    <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef SHA224_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready) begin
            win    <= blk_win;
            last_q <= blk_last;
            if (blk_first) begin
              av <= iv_sel;
              h  <= iv_sel;
`ifdef SHA224_MODE_EN
              mode_q <= mode224;
`endif
            end else begin
              av <= h;
            end
            digest_valid <= 1'b0;
            cnt          <= '0;
            blk_ready    <= 1'b0;
            busy         <= 1'b1;
            state        <= ROUNDS;
          end
        end
        ROUNDS: begin
          av  <= st[RPC];
          win <= win_nxt;
          if (cnt == CW'(NRND - RPC)) state <= UPDATE;
          else                        cnt   <= cnt + CW'(RPC);
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + av[i];
          if (last_q) digest_valid <= 1'b1;
          busy      <= 1'b0;
          blk_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core_v2.sv
// Bench for sha256_core_v2: three instances (RPC 1/2/4) against a per-cycle behavioural SHA-256 model.
module tb_sha256_core_v2;

  localparam int NI = 3;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC   = 512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
  localparam logic [511:0] EMPTY = 512'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [511:0] TB1   = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] TB2   = 512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;
  localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMP_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA224_MODE_EN
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] D224  = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
`endif

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid [NI];
  logic         in_first [NI];
  logic         in_last  [NI];
  logic [511:0] in_blk   [NI];
  logic         rdy [NI];
  logic         dv  [NI];
  logic         bsy [NI];
  logic [255:0] dig [NI];
`ifdef SHA224_MODE_EN
  logic         in_m224 [NI];
  logic         m_224   [NI];
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      sha256_core_v2 #(.RPC(1 << g), .NRND(64)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (in_valid[g]),
        .blk_ready    (rdy[g]),
        .blk_first    (in_first[g]),
        .blk_last     (in_last[g]),
`ifdef SHA224_MODE_EN
        .mode224      (in_m224[g]),
`endif
        .block        (in_blk[g]),
        .digest       (dig[g]),
        .digest_valid (dv[g]),
        .busy         (bsy[g])
      );
    end
  endgenerate

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression with feed-forward; chaining value packed H0 in the MSBs.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] iv_of(input int g);
`ifdef SHA224_MODE_EN
    if (in_m224[g]) return IV224;
`endif
    return IV256;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: handshake, latency 64/RPC+1 to update, chained hash values.
  logic [255:0] m_h [NI], m_pend [NI];
  logic         m_busy [NI], m_rdy [NI], m_dv [NI], m_last [NI];
  int           m_cnt [NI];

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_h[g] <= IV256; m_busy[g] <= 1'b0; m_rdy[g] <= 1'b0; m_dv[g] <= 1'b0; m_cnt[g] <= 0;
`ifdef SHA224_MODE_EN
        m_224[g] <= 1'b0;
`endif
      end else if (m_busy[g]) begin
        if (m_cnt[g] == 64 / (1 << g)) begin
          m_h[g] <= m_pend[g]; m_dv[g] <= m_last[g]; m_busy[g] <= 1'b0; m_rdy[g] <= 1'b1;
        end else begin
          m_cnt[g] <= m_cnt[g] + 1;
        end
      end else if (in_valid[g] && m_rdy[g]) begin
        if (in_first[g]) begin
          m_h[g] <= iv_of(g);
`ifdef SHA224_MODE_EN
          m_224[g] <= in_m224[g];
`endif
        end
        m_pend[g] <= compress(in_first[g] ? iv_of(g) : m_h[g], in_blk[g]);
        m_last[g] <= in_last[g]; m_dv[g] <= 1'b0; m_busy[g] <= 1'b1; m_cnt[g] <= 0; m_rdy[g] <= 1'b0;
      end else begin
        m_rdy[g] <= 1'b1;
      end
    end
  end

  function automatic logic [255:0] exp_dig(input int g);
`ifdef SHA224_MODE_EN
    if (m_224[g]) return {m_h[g][255:32], 32'h0};
`endif
    return m_h[g];
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("u%0d.blk_ready", g), 256'(rdy[g]), 256'(m_rdy[g]));
        chk($sformatf("u%0d.busy", g), 256'(bsy[g]), 256'(m_busy[g]));
        chk($sformatf("u%0d.digest_valid", g), 256'(dv[g]), 256'(m_dv[g]));
        chk($sformatf("u%0d.digest", g), dig[g], exp_dig(g));
      end
    end
  end

  // Present one block, hold valid through the rounds with junk on the other inputs, drop it when ready returns.
  task automatic send(input int g, input logic [511:0] b, input logic f, input logic l,
                      input int abort_at, output int lat);
    int n;
    in_blk[g] = b; in_first[g] = f; in_last[g] = l; in_valid[g] = 1'b1;
    n = 0;
    while (rdy[g] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL u%0d.accept_timeout: ready never rose within %0d cycles", g, n);
      in_valid[g] = 1'b0; lat = -1;
      return;
    end
    @(negedge clk);
    lat = 0;
    while (rdy[g] !== 1'b1 && lat < 300) begin
      if (abort_at > 0 && lat == abort_at) begin
        in_valid[g] = 1'b0;
        return;
      end
      in_blk[g] = rand_blk(); in_first[g] = 1'($urandom % 2); in_last[g] = 1'($urandom % 2);
      @(negedge clk); lat++;
    end
    in_valid[g] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0; in_first[g] = 1'b0; in_last[g] = 1'b0; in_blk[g] = '0;
`ifdef SHA224_MODE_EN
      in_m224[g] = 1'b0;
`endif
    end
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.digest", dig[0], IV256);
    chk("reset.blk_ready", 256'(rdy[0]), 256'(0));
    #1 rst = 1'b0;

    chk("model.abc", compress(IV256, ABC), ABC_D);
    chk("model.empty", compress(IV256, EMPTY), EMP_D);
    chk("model.two_block", compress(compress(IV256, TB1), TB2), TWO_D);

    // "abc" on each RPC variant; latency 65/33/17.
    for (int g = 0; g < NI; g++) begin
      send(g, ABC, 1'b1, 1'b1, 0, lat);
      chk($sformatf("u%0d.abc_latency", g), 256'(lat), 256'(64 / (1 << g) + 1));
      chk($sformatf("u%0d.abc_digest", g), dig[g], ABC_D);
      chk($sformatf("u%0d.abc_valid", g), 256'(dv[g]), 256'(1));
    end

    send(1, EMPTY, 1'b1, 1'b1, 0, lat);
    chk("u1.empty_digest", dig[1], EMP_D);

    for (int g = 0; g < NI; g += 2) begin
      send(g, TB1, 1'b1, 1'b0, 0, lat);
      chk($sformatf("u%0d.two_blk1_valid", g), 256'(dv[g]), 256'(0));
      send(g, TB2, 1'b0, 1'b1, 0, lat);
      chk($sformatf("u%0d.two_digest", g), dig[g], TWO_D);
    end

    // Reset in round 20, then rerun "abc".
    send(0, ABC, 1'b1, 1'b1, 20, lat);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst.digest", dig[0], IV256);
    chk("midrst.digest_valid", 256'(dv[0]), 256'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    send(0, ABC, 1'b1, 1'b1, 0, lat);
    chk("midrst.rerun_digest", dig[0], ABC_D);

    // Randomised blocks, first/last and idle gaps with junk inputs.
    for (int it = 0; it < 60; it++) begin
      int g;
      int gap;
      logic f;
      logic l;
      g = $urandom_range(0, NI - 1);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        in_blk[g] = rand_blk(); in_first[g] = 1'($urandom % 2); in_last[g] = 1'($urandom % 2);
        @(negedge clk);
      end
      f = ($urandom % 3) == 0;
      l = 1'($urandom % 2);
      send(g, rand_blk(), f, l, 0, lat);
      chk($sformatf("u%0d.rand_latency", g), 256'(lat), 256'(64 / (1 << g) + 1));
    end

`ifdef SHA224_MODE_EN
    chk("model.sha224", {compress(IV224, ABC)[255:32], 32'h0}, D224);
    in_m224[0] = 1'b1;
    send(0, ABC, 1'b1, 1'b1, 0, lat);
    in_m224[0] = 1'b0;
    chk("u0.sha224_digest", dig[0], D224);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
